spi_prog_loader: RTL and testbench
==================================

SPI_PROG_LOADER -- requirements
Module: spi_prog_loader

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2, number of flip-flops in the SCLK/CS/MOSI synchronizers (min 2).
REQ-002 SHALL have parameter IMEM_REGION, default 4'h1, addr[31:28] value selecting instruction memory.
REQ-003 SHALL have parameter PIM_REGION, default 4'h2, addr[31:28] value selecting the PIM buffer.
REQ-004 SHALL have one clock and an asynchronous, active-low reset: clk input 1, system clock; rst_n input 1, async active-low reset.
REQ-005 SHALL have sclk input 1, SPI clock from the host, asynchronous to clk.
REQ-006 SHALL have cs_n input 1, active-low chip select.
REQ-007 SHALL have mosi input 1, serial data, MSB first.
REQ-008 SHALL have miso output 1, serial status, MSB first.
REQ-009 SHALL have wr_valid output 1, a write request is pending.
REQ-010 SHALL have wr_ready input 1, the sink accepts the request.
REQ-011 SHALL have wr_addr output 32, byte address of the write.
REQ-012 SHALL have wr_data output 32, write data.
REQ-013 SHALL have wr_sel output 2: 01 selects imem, 10 selects PIM buffer, 00 when idle.
REQ-014 SHALL have err_sticky output 2: bit0 set on overflow, bit1 set on a bad region.

Function
REQ-015 SHALL synchronize sclk, cs_n and mosi through SYNC_STAGES flops and detect sclk edges in the clk domain (SPI mode 0); sclk period >= 8 clk cycles.
REQ-016 SHALL sample mosi on each synchronized sclk rise while cs_n is low, shifting MSB first; the 8th bit produces a one-cycle byte strobe.
REQ-017 SHALL clear the bit counter whenever cs_n is high, discarding partial bytes; command state SHALL persist across cs_n frames.
REQ-018 Command FSM states SHALL be IDLE, ADDR, DATA and ISSUE.
REQ-019 In IDLE, byte 0x01 SHALL go to ADDR, byte 0x02 SHALL go to DATA, and any other byte SHALL be ignored, staying in IDLE.
REQ-020 ADDR SHALL collect 4 bytes MSB-first into the address register, then return to IDLE; no write is issued.
REQ-021 DATA SHALL collect 4 bytes MSB-first into the data register; after the 4th byte it SHALL go to ISSUE.
REQ-022 ISSUE SHALL decode addr[31:28]: IMEM_REGION gives wr_sel=01, PIM_REGION gives wr_sel=10, then raise wr_valid the next cycle.
REQ-023 For any other region, ISSUE SHALL set err_sticky[1], raise no request, and return to IDLE.
REQ-024 wr_valid, wr_addr, wr_data and wr_sel SHALL stay stable until the cycle wr_valid and wr_ready are both high; wr_valid SHALL drop the following cycle and the FSM SHALL return to IDLE.
REQ-025 Latency from the 8th sclk rise of the last data byte to wr_valid SHALL be SYNC_STAGES+3 clk cycles maximum.
REQ-026 A byte strobe while wr_valid is pending SHALL be dropped and set err_sticky[0]; the pending write SHALL be unaffected.
REQ-027 The address register SHALL NOT auto-increment; every write uses the last loaded address.
REQ-028 miso SHALL shift out status byte {5'b0, err_sticky, wr_valid} captured at cs_n fall, updated on each sclk fall; miso SHALL be 0 when cs_n is high.
REQ-029 err_sticky SHALL clear only by reset.

Reset
REQ-030 Asserting rst_n low SHALL asynchronously force: FSM IDLE, wr_valid 0, wr_sel 00, wr_addr 0, wr_data 0, err_sticky 00, miso 0, bit and byte counters 0, synchronizers to idle level (sclk 0, cs_n 1).
REQ-031 Reset mid-transaction SHALL abandon the transaction with no write issued after release.
REQ-032 Release SHALL be glitch-free: the first byte after release requires a cs_n fall.

Structure
REQ-033 Shared package spi_prog_pkg SHALL hold opcode constants (OP_ADDR=8'h01, OP_DATA=8'h02), the FSM state enum and the wr_sel encodings.
REQ-034 Sub-module spi_byte_rx SHALL contain the synchronizers, edge detect, shift registers and bit counter; spi_prog_loader SHALL hold the command FSM and write port.

Verification
REQ-035 Bench SHALL cover: 01 10 00 00 00, then 02 DE AD BE EF, wr_ready=1 -> one write, wr_addr 32'h1000_0000, wr_data 32'hDEADBEEF, wr_sel 01.
REQ-036 Bench SHALL cover: address 32'h2000_0004, data 32'h0000_00A5, wr_ready held 0 for 50 cycles -> wr_valid and outputs stable for 50 cycles; extra byte sent meanwhile -> err_sticky 01, write still completes.
REQ-037 Bench SHALL cover: address 32'h3000_0000 then a data frame -> no wr_valid, err_sticky 10.
REQ-038 Bench SHALL cover: cs_n raised after 5 bits of 0x02, then full 02 11 22 33 44 -> exactly one write, wr_data 32'h11223344.
REQ-039 Bench SHALL cover: byte 0x7F, then 02 + 4 data bytes to prior address 32'h1000_0000 -> 0x7F ignored, one write at 32'h1000_0000.
REQ-040 Bench SHALL cover: rst_n pulsed low after 2 data bytes -> all outputs at reset values, no write after release.

Source files
------------

// File: rtl/spi_prog_pkg.sv
// Shared constants for the SPI program loader: opcodes, command FSM states
// and write-select encodings.
package spi_prog_pkg;

  localparam logic [7:0] OP_ADDR = 8'h01;
  localparam logic [7:0] OP_DATA = 8'h02;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ADDR  = 2'd1,
    ST_DATA  = 2'd2,
    ST_ISSUE = 2'd3
  } state_e;

  localparam logic [1:0] SEL_NONE = 2'b00;
  localparam logic [1:0] SEL_IMEM = 2'b01;
  localparam logic [1:0] SEL_PIM  = 2'b10;

endpackage

// File: rtl/spi_byte_rx.sv
// SPI mode-0 byte receiver in the clk domain: synchronizers, sclk edge
// detection, MSB-first receive shift with byte strobe, and status shift-out.
module spi_byte_rx #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sclk,
  input  logic       cs_n,
  input  logic       mosi,
  input  logic [7:0] status,
  output logic       miso,
  output logic       byte_valid,
  output logic [7:0] byte_data
);

  logic [SYNC_STAGES-1:0] sclk_sync;
  logic [SYNC_STAGES-1:0] cs_sync;
  logic [SYNC_STAGES-1:0] mosi_sync;
  logic [SYNC_STAGES:0]   prime;
  logic                   sclk_s, cs_s, mosi_s;
  logic                   sclk_prev, cs_prev, armed;
  logic                   sclk_rise, sclk_fall, cs_fall;
  logic [2:0]             bit_cnt;
  logic [6:0]             shift_q;
  logic [6:0]             tx_q;

  assign sclk_s    = sclk_sync[SYNC_STAGES-1];
  assign cs_s      = cs_sync[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_prev;
  assign sclk_fall = ~sclk_s & sclk_prev;
  // The chain resets to "cs high"; until it has flushed real pin values, a
  // low cs_n held through reset must not look like a fresh frame start.
  assign cs_fall   = prime[SYNC_STAGES] & cs_prev & ~cs_s;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_sync <= '0;
      cs_sync   <= '1;
      mosi_sync <= '0;
      prime     <= '0;
      sclk_prev <= 1'b0;
      cs_prev   <= 1'b1;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], cs_n};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
      prime     <= {prime[SYNC_STAGES-1:0], 1'b1};
      sclk_prev <= sclk_s;
      cs_prev   <= cs_s;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      armed      <= 1'b0;
      bit_cnt    <= 3'd0;
      shift_q    <= 7'd0;
      byte_valid <= 1'b0;
      byte_data  <= 8'd0;
    end else begin
      byte_valid <= 1'b0;
      if (cs_s) armed <= 1'b0;
      else if (cs_fall) armed <= 1'b1;
      if (cs_s || !armed) begin
        bit_cnt <= 3'd0;
      end else if (sclk_rise) begin
        shift_q <= {shift_q[5:0], mosi_s};
        bit_cnt <= bit_cnt + 3'd1;
        if (bit_cnt == 3'd7) begin
          byte_valid <= 1'b1;
          byte_data  <= {shift_q, mosi_s};
        end
      end
    end
  end

  // Status is latched at frame start so the host reads one coherent snapshot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      miso <= 1'b0;
      tx_q <= 7'd0;
    end else if (cs_s) begin
      miso <= 1'b0;
      tx_q <= 7'd0;
    end else if (cs_fall) begin
      miso <= status[7];
      tx_q <= status[6:0];
    end else if (armed && sclk_fall) begin
      miso <= tx_q[6];
      tx_q <= {tx_q[5:0], 1'b0};
    end
  end

endmodule

// File: rtl/spi_prog_loader.sv
// SPI program loader: decodes ADDR/DATA command frames into single-word
// writes toward instruction memory or the PIM buffer.
module spi_prog_loader
  import spi_prog_pkg::*;
#(
  parameter int         SYNC_STAGES = 2,
  parameter logic [3:0] IMEM_REGION = 4'h1,
  parameter logic [3:0] PIM_REGION  = 4'h2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        sclk,
  input  logic        cs_n,
  input  logic        mosi,
  output logic        miso,
  output logic        wr_valid,
  input  logic        wr_ready,
  output logic [31:0] wr_addr,
  output logic [31:0] wr_data,
  output logic [1:0]  wr_sel,
  output logic [1:0]  err_sticky,
  output logic [1:0]  dbg_state
);

  localparam logic [1:0] S_IDLE  = ST_IDLE;
  localparam logic [1:0] S_ADDR  = ST_ADDR;
  localparam logic [1:0] S_DATA  = ST_DATA;
  localparam logic [1:0] S_ISSUE = ST_ISSUE;

  logic [1:0]  state;
  logic [1:0]  byte_cnt;
  logic [31:0] addr_q;
  logic [31:0] data_q;
  logic        byte_valid;
  logic [7:0]  byte_data;

  spi_byte_rx #(.SYNC_STAGES(SYNC_STAGES)) u_rx (
    .clk        (clk),
    .rst_n      (rst_n),
    .sclk       (sclk),
    .cs_n       (cs_n),
    .mosi       (mosi),
    .status     ({5'b0, err_sticky, wr_valid}),
    .miso       (miso),
    .byte_valid (byte_valid),
    .byte_data  (byte_data)
  );

  assign wr_addr   = addr_q;
  assign wr_data   = data_q;
  assign dbg_state = state;

  // Write handshake: wr_valid with wr_addr/wr_data/wr_sel is held unchanged
  // until a cycle where wr_valid && wr_ready; wr_valid drops the next cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      byte_cnt   <= 2'd0;
      addr_q     <= 32'd0;
      data_q     <= 32'd0;
      wr_valid   <= 1'b0;
      wr_sel     <= SEL_NONE;
      err_sticky <= 2'b00;
    end else begin
      case (state)
        S_IDLE: begin
          if (byte_valid) begin
            byte_cnt <= 2'd0;
            if (byte_data == OP_ADDR) state <= S_ADDR;
            else if (byte_data == OP_DATA) state <= S_DATA;
          end
        end
        S_ADDR: begin
          if (byte_valid) begin
            addr_q   <= {addr_q[23:0], byte_data};
            byte_cnt <= byte_cnt + 2'd1;
            if (byte_cnt == 2'd3) state <= S_IDLE;
          end
        end
        S_DATA: begin
          if (byte_valid) begin
            data_q   <= {data_q[23:0], byte_data};
            byte_cnt <= byte_cnt + 2'd1;
            if (byte_cnt == 2'd3) state <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          // Bytes arriving while a write is outstanding have nowhere to go.
          if (byte_valid) err_sticky[0] <= 1'b1;
          if (!wr_valid) begin
            if (addr_q[31:28] == IMEM_REGION) begin
              wr_sel   <= SEL_IMEM;
              wr_valid <= 1'b1;
            end else if (addr_q[31:28] == PIM_REGION) begin
              wr_sel   <= SEL_PIM;
              wr_valid <= 1'b1;
            end else begin
              err_sticky[1] <= 1'b1;
              state         <= S_IDLE;
            end
          end else if (wr_ready) begin
            wr_valid <= 1'b0;
            wr_sel   <= SEL_NONE;
            state    <= S_IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_prog_loader.sv
// Self-checking bench for spi_prog_loader: SPI host driver, byte-level
// command model, write scoreboard and status read-back through miso.
module tb_spi_prog_loader;
  import spi_prog_pkg::*;

  localparam int         SYNC_STAGES = 2;
  localparam logic [3:0] IMEM_R      = 4'h1;
  localparam logic [3:0] PIM_R       = 4'h2;
  localparam int         SCLK_HALF   = 60;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        sclk = 1'b0;
  logic        cs_n = 1'b1;
  logic        mosi = 1'b0;
  logic        wr_ready = 1'b0;
  logic        miso, wr_valid;
  logic [31:0] wr_addr, wr_data;
  logic [1:0]  wr_sel, err_sticky, dbg_state;

  spi_prog_loader #(
    .SYNC_STAGES (SYNC_STAGES),
    .IMEM_REGION (IMEM_R),
    .PIM_REGION  (PIM_R)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .sclk       (sclk),
    .cs_n       (cs_n),
    .mosi       (mosi),
    .miso       (miso),
    .wr_valid   (wr_valid),
    .wr_ready   (wr_ready),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .wr_sel     (wr_sel),
    .err_sticky (err_sticky),
    .dbg_state  (dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  // scoreboard: {addr, data, sel}
  logic [65:0] exp_q[$];
  int          n_checks = 0;
  int          n_fail = 0;

  // reference model of the command protocol
  logic [1:0]  err_m = 2'b00;
  logic        pending_m = 1'b0;
  logic        armed_m = 1'b0;
  logic [7:0]  cmd_m = 8'h00;
  logic [7:0]  coll_q[$];
  logic [31:0] addr_m = 32'd0;
  logic [7:0]  exp_status;
  bit          first_byte = 0;
  time         t_last_rise = 0;
  logic        valid_d = 1'b0;

  task automatic model_reset();
    err_m = 2'b00; pending_m = 1'b0; armed_m = 1'b0;
    cmd_m = 8'h00; coll_q.delete(); addr_m = 32'd0;
    exp_q.delete(); first_byte = 0;
  endtask

  task automatic model_byte(input logic [7:0] b);
    logic [31:0] word;
    if (!armed_m) return;
    if (pending_m) begin
      err_m[0] = 1'b1;
      return;
    end
    if (cmd_m == 8'h00) begin
      if (b == OP_ADDR || b == OP_DATA) begin
        cmd_m = b;
        coll_q.delete();
      end
      return;
    end
    coll_q.push_back(b);
    if (coll_q.size() == 4) begin
      word = {coll_q[0], coll_q[1], coll_q[2], coll_q[3]};
      if (cmd_m == OP_ADDR) addr_m = word;
      else if (addr_m[31:28] == IMEM_R) begin
        exp_q.push_back({addr_m, word, SEL_IMEM}); pending_m = 1'b1;
      end else if (addr_m[31:28] == PIM_R) begin
        exp_q.push_back({addr_m, word, SEL_PIM}); pending_m = 1'b1;
      end else err_m[1] = 1'b1;
      cmd_m = 8'h00;
    end
  endtask

  // write-port monitor: every valid cycle must show the oldest expected write
  always @(negedge clk) begin
    int lat;
    if (rst_n && wr_valid) begin
      if (!valid_d) begin
        lat = int'(($time - t_last_rise) / 10);
        n_checks++;
        if (lat > SYNC_STAGES + 3) begin
          n_fail++;
          $display("FAIL latency: got %0d cycles, max %0d", lat, SYNC_STAGES + 3);
        end
      end
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_write: addr=%h data=%h sel=%b", wr_addr, wr_data, wr_sel);
      end else if ({wr_addr, wr_data, wr_sel} !== exp_q[0]) begin
        n_fail++;
        $display("FAIL write_fields: got %h/%h/%b expected %h/%h/%b", wr_addr, wr_data, wr_sel,
                 exp_q[0][65:34], exp_q[0][33:2], exp_q[0][1:0]);
      end
      if (wr_ready && exp_q.size() != 0) begin
        void'(exp_q.pop_front());
        pending_m = 1'b0;
      end
    end
    valid_d = wr_valid;
  end

  // driver tasks
  task automatic frame_begin();
    exp_status = {5'b0, err_m, pending_m};
    armed_m = 1'b1;
    first_byte = 1;
    cs_n = 1'b0;
    #(SCLK_HALF);
  endtask

  task automatic frame_end();
    #(SCLK_HALF);
    cs_n = 1'b1;
    armed_m = 1'b0;
    first_byte = 0;
    #(3 * SCLK_HALF);
  endtask

  task automatic spi_bits(input logic [7:0] b, input int n);
    for (int i = 7; i > 7 - n; i--) begin
      mosi = b[i];
      #(SCLK_HALF);
      sclk = 1'b1;
      t_last_rise = $time;
      #(SCLK_HALF);
      sclk = 1'b0;
    end
  endtask

  task automatic spi_byte(input logic [7:0] b);
    logic [7:0] rx;
    model_byte(b);
    for (int i = 7; i >= 0; i--) begin
      mosi = b[i];
      #(SCLK_HALF);
      rx[i] = miso;
      sclk = 1'b1;
      t_last_rise = $time;
      #(SCLK_HALF);
      sclk = 1'b0;
    end
    if (first_byte) begin
      first_byte = 0;
      n_checks++;
      if (rx !== exp_status) begin
        n_fail++;
        $display("FAIL miso_status: got %h expected %h", rx, exp_status);
      end
    end
  endtask

  task automatic send_word_frame(input logic [7:0] op, input logic [31:0] w);
    frame_begin();
    spi_byte(op);
    spi_byte(w[31:24]); spi_byte(w[23:16]); spi_byte(w[15:8]); spi_byte(w[7:0]);
    frame_end();
  endtask

  // drain expected writes; rnd toggles wr_ready randomly, else holds it high
  task automatic wait_writes(input bit rnd);
    int cyc = 0;
    while (exp_q.size() != 0 && cyc < 2000) begin
      @(posedge clk);
      #2;
      wr_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      cyc++;
    end
    @(negedge clk);
    wr_ready = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL write_timeout: %0d writes outstanding, required 0", exp_q.size());
    end
    n_checks++;
    if (wr_valid !== 1'b0 || wr_sel !== SEL_NONE) begin
      n_fail++;
      $display("FAIL idle_after_write: wr_valid=%b wr_sel=%b required 0/00", wr_valid, wr_sel);
    end
  endtask

  task automatic check_err(input string name);
    n_checks++;
    if (err_sticky !== err_m) begin
      n_fail++;
      $display("FAIL %s: err_sticky=%b expected %b", name, err_sticky, err_m);
    end
  endtask

  task automatic check_reset_outputs(input string name);
    n_checks++;
    if ({wr_valid, wr_sel, wr_addr, wr_data, err_sticky, miso} !== '0) begin
      n_fail++;
      $display("FAIL %s: valid=%b sel=%b addr=%h data=%h err=%b miso=%b, required all 0",
               name, wr_valid, wr_sel, wr_addr, wr_data, err_sticky, miso);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
  endtask

  // tests
  task automatic test_reset();
    rst_n = 1'b0;
    model_reset();
    repeat (4) @(negedge clk);
    check_reset_outputs("reset_state");
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    check_reset_outputs("after_release");
  endtask

  task automatic test_basic_write();
    wr_ready = 1'b1;
    send_word_frame(OP_ADDR, 32'h1000_0000);
    send_word_frame(OP_DATA, 32'hDEAD_BEEF);
    wait_writes(0);
    check_err("basic_err");
  endtask

  task automatic test_backpressure();
    int held = 0;
    int cyc = 0;
    wr_ready = 1'b0;
    send_word_frame(OP_ADDR, 32'h2000_0004);
    send_word_frame(OP_DATA, 32'h0000_00A5);
    while (!wr_valid && cyc < 300) begin
      @(negedge clk);
      cyc++;
    end
    repeat (50) begin
      @(negedge clk);
      if (wr_valid) held++;
    end
    n_checks++;
    if (held != 50) begin
      n_fail++;
      $display("FAIL backpressure_hold: wr_valid high %0d of 50 cycles", held);
    end
    frame_begin();
    spi_byte(8'h55);
    frame_end();
    check_err("overflow_err");
    n_checks++;
    if (wr_valid !== 1'b1 || exp_q.size() != 1) begin
      n_fail++;
      $display("FAIL overflow_pending: wr_valid=%b outstanding=%0d, required 1/1", wr_valid, exp_q.size());
    end
    wait_writes(0);
  endtask

  task automatic test_bad_region();
    do_reset();
    wr_ready = 1'b1;
    send_word_frame(OP_ADDR, 32'h3000_0000);
    send_word_frame(OP_DATA, 32'h1234_5678);
    repeat (50) @(negedge clk);
    check_err("bad_region_err");
    n_checks++;
    if (err_sticky !== 2'b10) begin
      n_fail++;
      $display("FAIL bad_region_value: err_sticky=%b required 10", err_sticky);
    end
    wait_writes(0);
  endtask

  task automatic test_abort_partial();
    wr_ready = 1'b1;
    send_word_frame(OP_ADDR, 32'h1000_0000);
    frame_begin();
    first_byte = 0;
    spi_bits(OP_DATA, 5);
    frame_end();
    send_word_frame(OP_DATA, 32'h1122_3344);
    wait_writes(0);
  endtask

  task automatic test_ignore_opcode();
    wr_ready = 1'b1;
    frame_begin();
    spi_byte(8'h7F);
    frame_end();
    send_word_frame(OP_DATA, 32'hCAFE_0001);
    wait_writes(0);
    check_err("ignore_err");
  endtask

  task automatic test_mid_reset();
    wr_ready = 1'b1;
    frame_begin();
    spi_byte(OP_DATA);
    spi_byte(8'hAA);
    spi_byte(8'hBB);
    @(negedge clk);
    rst_n = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    check_reset_outputs("mid_reset_outputs");
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    spi_byte(8'hCC);
    spi_byte(8'hDD);
    frame_end();
    repeat (200) @(negedge clk);
    check_reset_outputs("no_write_after_release");
    send_word_frame(OP_ADDR, 32'h1000_0008);
    send_word_frame(OP_DATA, 32'h0BAD_F00D);
    wait_writes(0);
  endtask

  task automatic test_random();
    logic [3:0]  reg_sel;
    logic [31:0] a, d;
    for (int n = 0; n < 8; n++) begin
      case ($urandom_range(0, 3))
        0, 1: reg_sel = IMEM_R;
        2: reg_sel = PIM_R;
        default: reg_sel = 4'($urandom_range(3, 15));
      endcase
      a = {reg_sel, 28'($urandom)};
      d = $urandom;
      wr_ready = 1'b0;
      send_word_frame(OP_ADDR, a);
      if ($urandom_range(0, 1) == 1) begin
        send_word_frame(OP_DATA, d);
      end else begin
        frame_begin();
        spi_byte(8'h7F);
        spi_byte(OP_DATA);
        spi_byte(d[31:24]); spi_byte(d[23:16]); spi_byte(d[15:8]); spi_byte(d[7:0]);
        frame_end();
      end
      wait_writes(1);
      check_err("random_err");
    end
  endtask

  initial begin
    test_reset();
    test_basic_write();
    test_backpressure();
    test_bad_region();
    test_abort_partial();
    test_ignore_opcode();
    test_mid_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
